// File: rtl/axil_pkg.sv
// Shared AXI4-Lite register-bank definitions: bus widths, response codes,
// write/read FSM states and the write holding-register payload.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_W = 7;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = 4;
  localparam int unsigned AXIL_IDX_W  = AXIL_ADDR_W - 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    HAVE_AW,
    HAVE_W,
    COMMIT,
    RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rd_state_e;

  // Latched AW index plus W payload, waiting for both halves of a write
  typedef struct packed {
    logic [AXIL_IDX_W-1:0]  idx;
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } wr_hold_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle (7-bit address, 32-bit data) with master/slave views.
interface axi_lite;
  import axil_pkg::*;

  logic                   awvalid;
  logic                   awready;
  logic [AXIL_ADDR_W-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [AXIL_DATA_W-1:0] wdata;
  logic [AXIL_STRB_W-1:0] wstrb;
  logic                   bvalid;
  logic                   bready;
  logic [1:0]             bresp;
  logic                   arvalid;
  logic                   arready;
  logic [AXIL_ADDR_W-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [AXIL_DATA_W-1:0] rdata;
  logic [1:0]             rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axil_byte_en_reg.sv
// One 32-bit register with asynchronous reset and per-byte write enables.
module axil_byte_en_reg
  import axil_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AXIL_STRB_W-1:0] byte_en,
  input  logic [AXIL_DATA_W-1:0] d,
  output logic [AXIL_DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int unsigned k = 0; k < AXIL_STRB_W; k++) begin
        if (byte_en[k]) q[8*k +: 8] <= d[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank feeding coefficients/control to the LMS core.
// Define AXIL_REG_BANK_SLVERR_EN to answer unmapped accesses with SLVERR.
module axi_lite_reg_bank
  import axil_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axi_lite.slave                   s_axi,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;
  wr_hold_t  hold;

  logic                   aw_hs, w_hs, ar_hs, commit;
  logic [NUM_REGS-1:0]    wr_sel;
  logic [AXIL_IDX_W-1:0]  ar_idx;
  logic [AXIL_DATA_W-1:0] rd_val;
  logic                   rd_hit;
  logic [AXIL_DATA_W-1:0] reg_q [NUM_REGS];
  logic                   unused_addr_lsbs;

  // Held flags and response-valid are decoded straight from the state register
  assign s_axi.awready = (wr_state == IDLE) || (wr_state == HAVE_W);
  assign s_axi.wready  = (wr_state == IDLE) || (wr_state == HAVE_AW);
  assign s_axi.bvalid  = (wr_state == RESP);
  assign s_axi.arready = (rd_state == R_IDLE);
  assign s_axi.rvalid  = (rd_state == R_VALID);

  assign aw_hs  = s_axi.awvalid && s_axi.awready;
  assign w_hs   = s_axi.wvalid  && s_axi.wready;
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign commit = (wr_state == COMMIT);
  assign ar_idx = s_axi.araddr[AXIL_ADDR_W-1:2];

  assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    case (wr_state)
      IDLE: begin
        if (aw_hs && w_hs) wr_next = COMMIT;
        else if (aw_hs)    wr_next = HAVE_AW;
        else if (w_hs)     wr_next = HAVE_W;
      end
      HAVE_AW: if (w_hs)  wr_next = COMMIT;
      HAVE_W:  if (aw_hs) wr_next = COMMIT;
      COMMIT:  wr_next = RESP;
      RESP:    if (s_axi.bready) wr_next = IDLE;
      default: wr_next = IDLE;
    endcase
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_VALID;
      R_VALID: if (s_axi.rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Address decode for the pending write and the incoming read
  always_comb begin
    wr_sel = '0;
    rd_val = '0;
    rd_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = (hold.idx == AXIL_IDX_W'(i));
      if (ar_idx == AXIL_IDX_W'(i)) begin
        rd_val = reg_q[i];
        rd_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      wr_pulse_o  <= '0;
      s_axi.bresp <= RESP_OKAY;
    end else begin
      if (aw_hs) hold.idx <= s_axi.awaddr[AXIL_ADDR_W-1:2];
      if (w_hs) begin
        hold.data <= s_axi.wdata;
        hold.strb <= s_axi.wstrb;
      end
      wr_pulse_o <= commit ? wr_sel : '0;
      if (commit) s_axi.bresp <= (|wr_sel) ? RESP_OKAY : UNMAPPED_RESP;
    end
  end

  // Read capture sees register values from before a same-edge commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi.rdata <= '0;
      s_axi.rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi.rdata <= rd_val;
      s_axi.rresp <= rd_hit ? RESP_OKAY : UNMAPPED_RESP;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    axil_byte_en_reg u_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .byte_en ((commit && wr_sel[g]) ? hold.strb : '0),
      .d       (hold.data),
      .q       (reg_q[g])
    );
    assign regs_o[32*g +: 32] = reg_q[g];
  end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Scoreboard bench for axi_lite_reg_bank; honours AXIL_REG_BANK_SLVERR_EN.
module tb_axi_lite_reg_bank;
  import axil_pkg::*;

  localparam int unsigned NUM_REGS = 16;
`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam logic [1:0] EXP_UNMAP = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_lite bus ();
  logic [NUM_REGS*32-1:0] regs;
  logic [NUM_REGS-1:0]    wr_pulse;

  axi_lite_reg_bank #(.NUM_REGS(NUM_REGS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi      (bus),
    .regs_o     (regs),
    .wr_pulse_o (wr_pulse)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [1:0]  exp_b_q [$];
  logic [33:0] exp_r_q [$];
  logic [NUM_REGS-1:0] pulse_acc = '0;

  always @(negedge clk) pulse_acc = pulse_acc | wr_pulse;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit ok);
    bus.awvalid = 1'b1; bus.awaddr = a;
    bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.bvalid) ok = 1'b1;
      else tick();
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [6:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output bit ok);
    bus.arvalid = 1'b1; bus.araddr = a;
    tick();
    bus.arvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      if (bus.rvalid) ok = 1'b1;
      else tick();
    end
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total_cnt++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111)
      $display("FAIL reset_ready got %b exp 111", {bus.awready, bus.wready, bus.arready});
    else pass_cnt++;
    #2 rst_n = 1'b1;
    tick();
    total_cnt++;
    if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0)
      $display("FAIL reset_resp got %b exp 000000", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp});
    else pass_cnt++;
    total_cnt++;
    if (bus.rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", bus.rdata);
    else pass_cnt++;
    total_cnt++;
    if (regs !== '0 || wr_pulse !== '0)
      $display("FAIL reset_regs got %h/%h exp 0/0", regs, wr_pulse);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd; logic [1:0] rr; bit ok; logic [33:0] er;
    bus.awvalid = 1'b1; bus.awaddr = 7'h08;
    bus.wvalid = 1'b1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
    exp_b_q.push_back(RESP_OKAY);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    total_cnt++;
    if (bus.bvalid !== 1'b0 || regs[32*2 +: 32] !== 32'h0)
      $display("FAIL sim_cycle1 got bvalid=%b reg2=%h exp 0/0", bus.bvalid, regs[32*2 +: 32]);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (regs[32*2 +: 32] !== 32'hDEADBEEF)
      $display("FAIL sim_reg2 got %h exp deadbeef", regs[32*2 +: 32]);
    else pass_cnt++;
    total_cnt++;
    if (wr_pulse !== 16'h0004) $display("FAIL sim_pulse got %h exp 0004", wr_pulse);
    else pass_cnt++;
    total_cnt++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== exp_b_q.pop_front())
      $display("FAIL sim_bresp got bvalid=%b bresp=%b exp 1/00", bus.bvalid, bus.bresp);
    else pass_cnt++;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    total_cnt++;
    if (wr_pulse !== '0 || bus.bvalid !== 1'b0)
      $display("FAIL sim_after got pulse=%h bvalid=%b exp 0/0", wr_pulse, bus.bvalid);
    else pass_cnt++;
    exp_r_q.push_back({RESP_OKAY, 32'hDEADBEEF});
    do_read(7'h08, rd, rr, ok);
    er = exp_r_q.pop_front();
    total_cnt++;
    if (!ok || {rr, rd} !== er) $display("FAIL sim_read got %h ok=%0d exp %h", {rr, rd}, ok, er);
    else pass_cnt++;
  endtask

  task automatic test_split_w_first();
    logic [31:0] rd; logic [1:0] rr, br; bit ok; logic [33:0] er; logic [1:0] eb;
    bus.wvalid = 1'b1; bus.wdata = 32'h11223344; bus.wstrb = 4'hF;
    exp_b_q.push_back(RESP_OKAY);
    tick();
    bus.wvalid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      total_cnt++;
      if (bus.awready !== 1'b1 || bus.wready !== 1'b0)
        $display("FAIL split_ready_c%0d got aw=%b w=%b exp 1/0", c, bus.awready, bus.wready);
      else pass_cnt++;
      if (c == 4) begin bus.awvalid = 1'b1; bus.awaddr = 7'h04; end
      tick();
    end
    bus.awvalid = 1'b0;
    total_cnt++;
    if (bus.bvalid !== 1'b0) $display("FAIL split_c5_bvalid got %b exp 0", bus.bvalid);
    else pass_cnt++;
    tick();
    eb = exp_b_q.pop_front();
    total_cnt++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== eb)
      $display("FAIL split_c6_bvalid got %b/%b exp 1/%b", bus.bvalid, bus.bresp, eb);
    else pass_cnt++;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    exp_b_q.push_back(RESP_OKAY);
    do_write(7'h04, 32'hAABBCCDD, 4'h5, br, ok);
    eb = exp_b_q.pop_front();
    total_cnt++;
    if (!ok || br !== eb) $display("FAIL split_strb_bresp got %b ok=%0d exp %b", br, ok, eb);
    else pass_cnt++;
    exp_r_q.push_back({RESP_OKAY, 32'h11BB33DD});
    do_read(7'h04, rd, rr, ok);
    er = exp_r_q.pop_front();
    total_cnt++;
    if (!ok || {rr, rd} !== er) $display("FAIL split_strb_read got %h exp %h", {rr, rd}, er);
    else pass_cnt++;
  endtask

  task automatic test_stalled();
    logic [1:0] eb;
    bus.awvalid = 1'b1; bus.awaddr = 7'h0C;
    bus.wvalid = 1'b1; bus.wdata = 32'h12345678; bus.wstrb = 4'hF;
    exp_b_q.push_back(RESP_OKAY);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    eb = exp_b_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if ({bus.bvalid, bus.awready, bus.wready, bus.bresp} !== {3'b100, eb})
        $display("FAIL stall_%0d got %b exp %b", k, {bus.bvalid, bus.awready, bus.wready, bus.bresp},
                 {3'b100, eb});
      else pass_cnt++;
      tick();
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    total_cnt++;
    if (bus.bvalid !== 1'b0) $display("FAIL stall_release got %b exp 0", bus.bvalid);
    else pass_cnt++;
  endtask

  task automatic test_unmapped();
    logic [NUM_REGS*32-1:0] snap; logic [31:0] rd; logic [1:0] rr, br; bit ok;
    logic [1:0] eb; logic [33:0] er;
    snap = regs;
    pulse_acc = '0;
    exp_b_q.push_back(EXP_UNMAP);
    do_write(7'h7C, 32'hFFFFFFFF, 4'hF, br, ok);
    eb = exp_b_q.pop_front();
    total_cnt++;
    if (!ok || br !== eb) $display("FAIL unmap_bresp got %b ok=%0d exp %b", br, ok, eb);
    else pass_cnt++;
    total_cnt++;
    if (regs !== snap || pulse_acc !== '0)
      $display("FAIL unmap_side_effect got pulse=%h regs_changed=%0d exp 0/0", pulse_acc, regs !== snap);
    else pass_cnt++;
    exp_r_q.push_back({EXP_UNMAP, 32'h0});
    do_read(7'h7C, rd, rr, ok);
    er = exp_r_q.pop_front();
    total_cnt++;
    if (!ok || {rr, rd} !== er) $display("FAIL unmap_read got %h exp %h", {rr, rd}, er);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [31:0] rd; logic [1:0] rr; bit ok; logic [33:0] er; logic [1:0] eb;
    bus.awvalid = 1'b1; bus.awaddr = 7'h00;
    bus.wvalid = 1'b1; bus.wdata = 32'h5; bus.wstrb = 4'hF;
    exp_b_q.push_back(RESP_OKAY);
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 7'h00;
    exp_r_q.push_back({RESP_OKAY, 32'h0});
    tick();
    bus.arvalid = 1'b0;
    er = exp_r_q.pop_front();
    eb = exp_b_q.pop_front();
    total_cnt++;
    if ({bus.rvalid, bus.rresp, bus.rdata} !== {1'b1, er})
      $display("FAIL collide_read got %h exp %h", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, er});
    else pass_cnt++;
    total_cnt++;
    if (bus.bvalid !== 1'b1 || bus.bresp !== eb)
      $display("FAIL collide_bresp got %b/%b exp 1/%b", bus.bvalid, bus.bresp, eb);
    else pass_cnt++;
    bus.rready = 1'b1; bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0; bus.bready = 1'b0;
    exp_r_q.push_back({RESP_OKAY, 32'h5});
    do_read(7'h00, rd, rr, ok);
    er = exp_r_q.pop_front();
    total_cnt++;
    if (!ok || {rr, rd} !== er) $display("FAIL collide_reread got %h exp %h", {rr, rd}, er);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int nb, nr; logic [1:0] eb; logic [33:0] er;
    nb = 0; nr = 0;
    bus.awvalid = 1'b1; bus.awaddr = 7'h14;
    bus.wvalid = 1'b1; bus.wdata = 32'h000000A5; bus.wstrb = 4'hF;
    bus.bready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.awready) exp_b_q.push_back(RESP_OKAY);
      if (bus.bvalid) begin
        nb++;
        eb = exp_b_q.pop_front();
        total_cnt++;
        if (bus.bresp !== eb) $display("FAIL b2b_bresp_c%0d got %b exp %b", c, bus.bresp, eb);
        else pass_cnt++;
      end
      tick();
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    total_cnt++;
    if (nb != 4 || exp_b_q.size() != 0)
      $display("FAIL b2b_write_rate got %0d pending=%0d exp 4/0", nb, exp_b_q.size());
    else pass_cnt++;
    bus.arvalid = 1'b1; bus.araddr = 7'h14; bus.rready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.arready) exp_r_q.push_back({RESP_OKAY, 32'h000000A5});
      if (bus.rvalid) begin
        nr++;
        er = exp_r_q.pop_front();
        total_cnt++;
        if ({bus.rresp, bus.rdata} !== er)
          $display("FAIL b2b_read_c%0d got %h exp %h", c, {bus.rresp, bus.rdata}, er);
        else pass_cnt++;
      end
      tick();
    end
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    total_cnt++;
    if (nr != 6 || exp_r_q.size() != 0)
      $display("FAIL b2b_read_rate got %0d pending=%0d exp 6/0", nr, exp_r_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rr, br; bit ok; logic [33:0] er; logic [1:0] eb;
    bus.awvalid = 1'b1; bus.awaddr = 7'h18;
    tick();
    bus.awvalid = 1'b0;
    total_cnt++;
    if (bus.awready !== 1'b0 || bus.wready !== 1'b1)
      $display("FAIL rstmid_held got aw=%b w=%b exp 0/1", bus.awready, bus.wready);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100)
      $display("FAIL rstmid_async got %b exp 11100",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    else pass_cnt++;
    total_cnt++;
    if (regs !== '0 || wr_pulse !== '0)
      $display("FAIL rstmid_regs got %h/%h exp 0/0", regs, wr_pulse);
    else pass_cnt++;
    tick();
    #2 rst_n = 1'b1;
    tick();
    exp_b_q.push_back(RESP_OKAY);
    do_write(7'h18, 32'hCAFEF00D, 4'hF, br, ok);
    eb = exp_b_q.pop_front();
    total_cnt++;
    if (!ok || br !== eb) $display("FAIL rstmid_write got %b ok=%0d exp %b", br, ok, eb);
    else pass_cnt++;
    exp_r_q.push_back({RESP_OKAY, 32'hCAFEF00D});
    do_read(7'h18, rd, rr, ok);
    er = exp_r_q.pop_front();
    total_cnt++;
    if (!ok || {rr, rd} !== er) $display("FAIL rstmid_read got %h exp %h", {rr, rd}, er);
    else pass_cnt++;
  endtask

  initial begin
    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready  = 1'b0;
    test_reset();
    test_simultaneous();
    test_split_w_first();
    test_stalled();
    test_unmapped();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_bank.md
# axi_lite_reg_bank

AXI4-Lite slave register bank on the far side of the transmitter's `axi_lite` link. It accepts single-beat writes and reads, stores them in `NUM_REGS` 32-bit registers with byte enables, and presents the register contents and per-register write pulses to the LMS filter core as coefficient and control values.

## Interface
- `NUM_REGS`, default 16: number of mapped 32-bit registers, range 1..32.
- `clk  in  1`: single clock.
- `rst_n  in  1`: reset, asynchronous assert, active-low.
- `s_axi  axi_lite.slave`: 7-bit address, 32-bit data, 4-bit strobe.
- `regs_o  out  NUM_REGS*32`: register contents; register i is at `[32*i +: 32]`.
- `wr_pulse_o  out  NUM_REGS`: bit i is high for 1 cycle when register i is written.

## Operation
- Address decode: `index = addr[6:2]`, with `addr[1:0]` ignored. An address is mapped when `index < NUM_REGS`.
- **Write path (AW and W channels):**
  - AW and W are accepted independently, in either order.
  - Each accepted channel is latched into a holding register with a held flag: `aw_held`, `w_held`.
  - `awready = !aw_held && !bvalid`.
  - `wready = !w_held && !bvalid`.
- **Write commit:**
  - Occurs on the first edge at which `aw_held && w_held` are both registered high.
  - A mapped address updates byte k of the target register only where `wstrb[k]=1`. That register's `wr_pulse_o` bit is set high for the following cycle.
  - The commit clears both held flags and sets `bvalid`.
- **Write response:**
  - `bvalid` holds, with `bresp` stable, until the `bvalid && bready` edge, then clears.
  - No new AW or W is accepted while `bvalid` is high.
- **Read path:**
  - `arready = !rvalid`.
  - On an `arvalid && arready` edge, `rdata` is loaded with the register value *before* any commit on that same edge, and `rvalid` is set.
  - `rvalid`, `rdata` and `rresp` hold until the `rvalid && rready` edge.
  - An unmapped read returns `rdata = 0`.
- Read and write paths are fully independent. A read and a write commit may complete on the same edge.
- **FSM (write):**
  - States: IDLE (none held), HAVE_AW, HAVE_W, COMMIT (both held), RESP (`bvalid`).
  - Transitions: IDLE→HAVE_AW/HAVE_W/COMMIT according to which handshakes occur; HAVE_x→COMMIT; COMMIT→RESP; RESP→IDLE on `bready`.
- **FSM (read):** R_IDLE → R_VALID on AR handshake; R_VALID → R_IDLE on `rready`.

## Timing
- Reset values:
  - All registers = 0; `wr_pulse_o` = 0.
  - `bvalid`, `rvalid` = 0; `bresp`, `rresp` = OKAY; `rdata` = 0.
  - `awready`, `wready`, `arready` = 1 (derived from reset state).
- Write latency with AW and W on the same edge, at cycle 0:
  - Both held in cycle 1; commit on the end-of-cycle-1 edge.
  - `regs_o`, `wr_pulse_o` and `bvalid` all change at cycle 2.
- Write with AW at cycle 0 and W at cycle 3: commit edge at the end of cycle 4, `bvalid` at cycle 5.
- Read latency: `rvalid` is high on the cycle after the AR handshake.
- Back-to-back throughput:
  - One write per 3 cycles when `bready` is held high.
  - One read per 2 cycles when `rready` is held high.
- Reset mid-transaction:
  - Held flags, `bvalid` and `rvalid` clear immediately (asynchronously).
  - A partially held write is discarded and no register changes.

## Configuration
- The macro `AXIL_REG_BANK_SLVERR_EN` selects the response on unmapped addresses. It has no effect on mapped addresses, which always return OKAY.
- **Defined:**
  - An unmapped write returns `bresp = 2'b10` (SLVERR).
  - An unmapped read returns `rresp = 2'b10` with `rdata = 0`.
- **Undefined:**
  - An unmapped write returns `bresp = 2'b00` (OKAY) and is dropped silently.
  - An unmapped read returns OKAY with `rdata = 0`.

## Structure
- Shared package `axil_pkg` holds:
  - `AXIL_ADDR_W = 7`, `AXIL_DATA_W = 32`, `AXIL_STRB_W = 4`.
  - `RESP_OKAY = 2'b00`, `RESP_SLVERR = 2'b10`.
  - The write and read FSM state enums.
- One natural sub-module: `axil_byte_en_reg`, a single 32-bit register with async reset and a 4-bit byte-write enable. It is instantiated `NUM_REGS` times by a generate loop.

## Test plan
- **Simultaneous AW/W:** write addr 0x08, data 0xDEADBEEF, strb 0xF →
  - `regs_o[2]` = 0xDEADBEEF at cycle 2;
  - `wr_pulse_o` = 0x0004 for 1 cycle;
  - `bresp` = OKAY;
  - a read of 0x08 returns 0xDEADBEEF.
- **Split channels, W first:**
  - W data 0x11223344 at cycle 0, AW addr 0x04 at cycle 4 → `awready` stays 1 and `wready` = 0 during cycles 1–4; `bvalid` rises at cycle 6.
  - A later write of 0xAABBCCDD with strb 0x5 to the same address → result 0x11BB33DD.
- **Stalled response:** hold `bready` = 0 for 5 cycles → `bvalid` and `bresp` stay stable, and `awready` = `wready` = 0 throughout. Drop to `bready` = 1 → `bvalid` clears on the next edge.
- **Unmapped access, `NUM_REGS` = 16:** write and read addr 0x7C →
  - no register changes and `wr_pulse_o` = 0;
  - with the macro defined, `bresp` = `rresp` = 2'b10; without it, 2'b00;
  - `rdata` = 0 in both cases.
- **Same-edge collision:** a read of 0x00 with AR handshake on the write-commit edge of 0x00 (new 0x5, old 0x0) → `rdata` = 0x0; a subsequent read returns 0x5.
- **Reset mid-write:** assert `rst_n` = 0 while AW is held, before W arrives → all outputs return to their reset values asynchronously, and after release a fresh write completes normally.
